// File: rtl/mdio_mgmt_arbiter.sv
// Shares one Clause-22 MDIO frame engine between the host register interface
// and a PHY status autopoller, with round-robin arbitration and a WAIT timeout.
module mdio_mgmt_arbiter #(
  parameter logic [4:0] PHY_ADDR    = 5'h05,
  parameter logic [4:0] POLL_REG    = 5'h01,
  parameter int         POLL_PERIOD = 1000,
  parameter int         TIMEOUT     = 128
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        HOST_REQ,
  input  logic        HOST_RW,
  input  logic [4:0]  HOST_REG,
  input  logic [15:0] HOST_WDATA,
  output logic        HOST_ACK,
  output logic [15:0] HOST_RDATA,
  output logic        HOST_ERR,
  input  logic        POLL_EN,
  output logic [15:0] POLL_STATUS,
  output logic        POLL_VALID,
  output logic        POLL_CHANGE,
  output logic        MDIO_START,
  output logic [31:0] MDIO_OUT,
  input  logic        MDIO_DONE,
  input  logic [15:0] RD_DATA,
  output logic        BUSY
);

  localparam int PCW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [PCW-1:0] POLL_RELOAD = PCW'(POLL_PERIOD - 1);
  localparam logic [TCW-1:0] TMO_LAST    = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           grant_s;
  logic           grant_poll_s;
  logic           wait_exit_s;
  logic           wait_ok_s;
  logic           grant_poll_r;
  logic           last_poll_r;
  logic           host_rw_r;
  logic [TCW-1:0] tmo_cnt_r;
  logic [PCW-1:0] poll_cnt_r;
  logic           poll_pending_r;

  logic           host_ack_r;
  logic           host_err_r;
  logic [15:0]    host_rdata_r;
  logic [15:0]    poll_status_r;
  logic           poll_valid_r;
  logic           poll_change_r;
  logic           mdio_start_r;
  logic [31:0]    mdio_out_r;
  logic           busy_r;

  // Clause-22 frame: ST, OP, PHYAD, REGAD, TA, DATA.
  function automatic logic [31:0] build_frame(input logic wr,
                                              input logic [4:0] reg_addr,
                                              input logic [15:0] wdata);
    logic [1:0]  op;
    logic [15:0] data;
    op   = wr ? 2'b01 : 2'b10;
    data = wr ? wdata : 16'h0000;
    return {2'b01, op, PHY_ADDR, reg_addr, 2'b10, data};
  endfunction

  // Next-state, arbitration and WAIT-exit decisions.
  always_comb begin
    state_nxt_s  = state_r;
    grant_s      = 1'b0;
    grant_poll_s = 1'b0;
    wait_exit_s  = 1'b0;
    wait_ok_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // On a tie the requester that did not win last time gets the engine.
        if (HOST_REQ && poll_pending_r) begin
          grant_s      = 1'b1;
          grant_poll_s = ~last_poll_r;
        end else if (HOST_REQ) begin
          grant_s      = 1'b1;
          grant_poll_s = 1'b0;
        end else if (poll_pending_r) begin
          grant_s      = 1'b1;
          grant_poll_s = 1'b1;
        end else begin
          grant_s      = 1'b0;
          grant_poll_s = 1'b0;
        end
        if (grant_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nxt_s = ST_START;
      ST_START: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (MDIO_DONE) begin
          wait_exit_s = 1'b1;
          wait_ok_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          wait_exit_s = 1'b1;
          wait_ok_s   = 1'b0;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, grant bookkeeping and WAIT timeout counter.
  always_ff @(posedge MDC) begin
    if (!RESET) begin
      state_r      <= ST_IDLE;
      grant_poll_r <= 1'b0;
      last_poll_r  <= 1'b1;
      host_rw_r    <= 1'b0;
      tmo_cnt_r    <= {TCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        grant_poll_r <= grant_poll_s;
        last_poll_r  <= grant_poll_s;
        host_rw_r    <= HOST_RW;
      end
      if (state_r == ST_LOAD) begin
        tmo_cnt_r <= {TCW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        tmo_cnt_r <= tmo_cnt_r + TCW'(1);
      end
    end
  end

  // Autopoll timer; a fresh expiry outranks the grant that consumes the old one.
  always_ff @(posedge MDC) begin
    if (!RESET) begin
      poll_cnt_r     <= POLL_RELOAD;
      poll_pending_r <= 1'b0;
    end else if (!POLL_EN) begin
      poll_cnt_r     <= POLL_RELOAD;
      poll_pending_r <= 1'b0;
    end else if (poll_cnt_r == {PCW{1'b0}}) begin
      poll_cnt_r     <= POLL_RELOAD;
      poll_pending_r <= 1'b1;
    end else begin
      poll_cnt_r <= poll_cnt_r - PCW'(1);
      if (grant_s && grant_poll_s) begin
        poll_pending_r <= 1'b0;
      end
    end
  end

  // Engine-side outputs: frame register, start pulse and busy flag.
  always_ff @(posedge MDC) begin
    if (!RESET) begin
      mdio_out_r   <= 32'h0000_0000;
      mdio_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      mdio_start_r <= (state_r == ST_LOAD);
      busy_r       <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_LOAD) begin
        if (grant_poll_r) begin
          mdio_out_r <= build_frame(1'b0, POLL_REG, 16'h0000);
        end else begin
          mdio_out_r <= build_frame(HOST_RW, HOST_REG, HOST_WDATA);
        end
      end
    end
  end

  // Requester-side responses, presented during RESP.
  always_ff @(posedge MDC) begin
    if (!RESET) begin
      host_ack_r    <= 1'b0;
      host_err_r    <= 1'b0;
      host_rdata_r  <= 16'h0000;
      poll_status_r <= 16'h0000;
      poll_valid_r  <= 1'b0;
      poll_change_r <= 1'b0;
    end else begin
      host_ack_r    <= wait_exit_s && !grant_poll_r;
      host_err_r    <= wait_exit_s && !grant_poll_r && !wait_ok_s;
      poll_change_r <= 1'b0;
      if (wait_exit_s && wait_ok_s && !grant_poll_r && !host_rw_r) begin
        host_rdata_r <= RD_DATA;
      end
      if (wait_exit_s && grant_poll_r) begin
        if (wait_ok_s) begin
          poll_status_r <= RD_DATA;
          poll_valid_r  <= 1'b1;
          poll_change_r <= !poll_valid_r || (RD_DATA != poll_status_r);
        end else begin
          poll_valid_r  <= 1'b0;
        end
      end
    end
  end

  assign HOST_ACK    = host_ack_r;
  assign HOST_ERR    = host_err_r;
  assign HOST_RDATA  = host_rdata_r;
  assign POLL_STATUS = poll_status_r;
  assign POLL_VALID  = poll_valid_r;
  assign POLL_CHANGE = poll_change_r;
  assign MDIO_START  = mdio_start_r;
  assign MDIO_OUT    = mdio_out_r;
  assign BUSY        = busy_r;

endmodule

// File: doc/mdio_mgmt_arbiter.md
Name: mdio_mgmt_arbiter

Overview:
- Management-side controller that shares a single MDIO frame engine between two requesters: the host register interface and an internal PHY status autopoller.
- Arbitrates between them round-robin and assembles the 32-bit Clause-22 frame.
- Pulses the engine start, waits for MDIO_DONE with a timeout, then routes read data or an error back to the granted requester.
- Sits between the host/CSR logic and the serial MDIO transmitter/receiver pair.

Parameters:
- PHY_ADDR, 5'h05, PHY address placed in every frame.
- POLL_REG, 5'h01, register read by the autopoller.
- POLL_PERIOD, 1000, MDC cycles between autopoll requests (≥2).
- TIMEOUT, 128, maximum MDC cycles in WAIT before abort (≥70).

Ports:
- MDC  in  1  clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous, active-low (0 = reset).
- HOST_REQ  in  1  host request, level; held until HOST_ACK.
- HOST_RW  in  1  1 = write, 0 = read; stable while HOST_REQ is high.
- HOST_REG  in  5  register address.
- HOST_WDATA  in  16  write data.
- HOST_ACK  out  1  one-cycle completion pulse.
- HOST_RDATA  out  16  read data; valid with HOST_ACK on a read.
- HOST_ERR  out  1  valid with HOST_ACK; 1 = timeout.
- POLL_EN  in  1  autopoll enable.
- POLL_STATUS  out  16  last successfully polled value.
- POLL_VALID  out  1  POLL_STATUS holds a good value.
- POLL_CHANGE  out  1  one-cycle pulse when POLL_STATUS is updated to a new value.
- MDIO_START  out  1  one-cycle start pulse to the frame engine.
- MDIO_OUT  out  32  frame to the engine.
- MDIO_DONE  in  1  engine completion pulse.
- RD_DATA  in  16  engine read data; valid with MDIO_DONE.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RESET = 0 at a clock edge): state IDLE; all outputs 0; MDIO_OUT = 0; poll counter = POLL_PERIOD-1; poll_pending = 0; last_grant = POLL, so the host wins the first tie. Reset mid-transaction abandons it; no ACK is issued.
- Frame layout:
  - [31:30] = 2'b01.
  - [29:28] = 2'b01 for write, 2'b10 for read.
  - [27:23] = PHY_ADDR.
  - [22:18] = register address.
  - [17:16] = 2'b10.
  - [15:0] = HOST_WDATA for a write, 16'h0000 for a read.
  - Poll frames are always reads of POLL_REG.
- Poll timer:
  - While POLL_EN = 1, the counter decrements each cycle.
  - At 0 it sets poll_pending and reloads POLL_PERIOD-1.
  - POLL_EN = 0 holds the counter at reload and clears poll_pending; a poll transaction already granted completes normally.
  - The timer keeps running during transactions. A second expiry while poll_pending is still set is absorbed; there is no queueing.
- State machine: IDLE → LOAD → START → WAIT → RESP → IDLE.
  - IDLE: requesters are HOST_REQ and poll_pending.
    - If only one is active, grant it.
    - If both are active, grant the one that is not last_grant.
    - On grant, record last_grant; a poll grant clears poll_pending.
  - LOAD: register the frame into MDIO_OUT (held until the next LOAD); clear the timeout counter.
  - START: MDIO_START = 1 for exactly this cycle.
  - WAIT: timeout counter increments each cycle.
    - MDIO_DONE = 1 → RESP with ok.
    - Counter reaches TIMEOUT-1 without MDIO_DONE → RESP with err.
    - If MDIO_DONE and the timeout arrive in the same cycle, DONE wins.
    - RD_DATA is captured on MDIO_DONE.
  - RESP (one cycle):
    - Host grant: HOST_ACK = 1 and HOST_ERR = err. On an ok read, HOST_RDATA ← captured data. HOST_RDATA is otherwise unchanged.
    - Poll grant, ok: POLL_STATUS ← data and POLL_VALID ← 1. POLL_CHANGE = 1 if POLL_VALID was 0 or the data differs from the old POLL_STATUS.
    - Poll grant, err: POLL_VALID ← 0; POLL_STATUS is held; no POLL_CHANGE.
- Outside WAIT, MDIO_DONE is ignored.
- Requests are not sampled in RESP. If HOST_REQ is still high in the IDLE cycle after ACK, that is a new transaction.
- Host latency: REQ seen in IDLE at cycle t; MDIO_START at t+2; MDIO_DONE at t+k (k ≥ 3) gives HOST_ACK at t+k+1.
- HOST_ACK, POLL_CHANGE and MDIO_START are single-cycle pulses.

Test Plan:
- Host write, HOST_REG = 5'h04, HOST_WDATA = 16'h8FF1, POLL_EN = 0 → MDIO_OUT = 32'h52928FF1; MDIO_START 2 cycles after REQ. With DONE 64 cycles after START, HOST_ACK fires 1 cycle after DONE with HOST_ERR = 0 and HOST_RDATA unchanged.
- Host read, HOST_REG = 5'h02, engine RD_DATA = 16'hA5A5 → MDIO_OUT = 32'h628A0000; at ACK, HOST_RDATA = 16'hA5A5 and HOST_ERR = 0.
- Autopoll with POLL_PERIOD = 20 and RD_DATA = 16'h796D, then 16'h796D, then 16'h7969:
  - each frame is 32'h62860000;
  - POLL_CHANGE pulses on the 1st and 3rd polls only;
  - POLL_VALID = 1 after the 1st.
- Simultaneous HOST_REQ and poll_pending, first after reset → host is granted first, poll next. On the next tie, poll wins (round-robin).
- MDIO_DONE never asserted → after TIMEOUT cycles in WAIT, HOST_ACK = 1 with HOST_ERR = 1 and HOST_RDATA unchanged. The same case on a poll clears POLL_VALID.
- RESET driven low during WAIT → next cycle: IDLE, BUSY = 0, all outputs 0, no HOST_ACK. A late MDIO_DONE after reset is ignored.
